// File: rtl/clock_set_controller.sv
// clock_set_controller: time-set sequencer for the HH:MM:SS BCD counters.
// Debounces mode/inc/dec, walks hours -> minutes -> seconds -> commit,
// freezes the counters while editing and blinks the field being edited.
// Optional build macro: CLOCK_SET_AUTO_REPEAT_EN (auto-repeat of held inc/dec
// in the hour and minute fields).
module clock_set_controller #(
  parameter int unsigned DEBOUNCE_CYCLES = 1000000,
  parameter int unsigned TIMEOUT_S       = 10,
  parameter int unsigned REPEAT_DELAY    = 50000000,
  parameter int unsigned REPEAT_CYCLES   = 12500000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       btn_mode,
  input  logic       btn_inc,
  input  logic       btn_dec,
  input  logic       tick_1hz,
  input  logic [1:0] cur_hr_tens,
  input  logic [3:0] cur_hr_ones,
  input  logic [2:0] cur_min_tens,
  input  logic [3:0] cur_min_ones,
  input  logic [2:0] cur_sec_tens,
  input  logic [3:0] cur_sec_ones,
  output logic       count_en,
  output logic       load,
  output logic [1:0] ld_hr_tens,
  output logic [3:0] ld_hr_ones,
  output logic [2:0] ld_min_tens,
  output logic [3:0] ld_min_ones,
  output logic [2:0] ld_sec_tens,
  output logic [3:0] ld_sec_ones,
  output logic [5:0] blank_mask,
  output logic [2:0] edit_state
);

  localparam logic [2:0] RUN     = 3'd0;
  localparam logic [2:0] SET_HR  = 3'd1;
  localparam logic [2:0] SET_MIN = 3'd2;
  localparam logic [2:0] SET_SEC = 3'd3;
  localparam logic [2:0] COMMIT  = 3'd4;

  localparam int unsigned DW = $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [DW-1:0] DB_LAST = DW'(DEBOUNCE_CYCLES - 1);
  localparam int unsigned TW = $clog2(TIMEOUT_S + 1);
  localparam logic [TW-1:0] TO_LAST = TW'(TIMEOUT_S - 1);

  // button index: 0 = mode, 1 = inc, 2 = dec
  logic [2:0]    btn_raw, sync1, sync2, db, db_q, press;
  logic [DW-1:0] db_cnt [3];

  logic [2:0]    state;
  logic [TW-1:0] idle_cnt;
  logic          phase;
  logic          in_set, timeout;
  logic          ev_inc, ev_dec, act_mode, act_inc, act_dec;
  logic          rpt_inc, rpt_dec;

  logic [1:0] e_hr_t;  logic [3:0] e_hr_o;
  logic [2:0] e_min_t; logic [3:0] e_min_o;
  logic [2:0] e_sec_t; logic [3:0] e_sec_o;
  logic [1:0] nh_t;    logic [3:0] nh_o;
  logic [2:0] nm_t;    logic [3:0] nm_o;

  assign btn_raw = {btn_dec, btn_inc, btn_mode};

  // two-flop synchronizer for the raw buttons
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync1 <= '0;
      sync2 <= '0;
    end else begin
      sync1 <= btn_raw;
      sync2 <= sync1;
    end
  end

  // debounce: level flips after DEBOUNCE_CYCLES consecutive differing samples
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      db   <= '0;
      db_q <= '0;
      for (int unsigned i = 0; i < 3; i++) db_cnt[i] <= '0;
    end else begin
      db_q <= db;
      for (int unsigned i = 0; i < 3; i++) begin
        if (sync2[i] == db[i]) begin
          db_cnt[i] <= '0;
        end else if (db_cnt[i] == DB_LAST) begin
          db[i]     <= sync2[i];
          db_cnt[i] <= '0;
        end else begin
          db_cnt[i] <= db_cnt[i] + 1'b1;
        end
      end
    end
  end

  assign press = db & ~db_q;

`ifdef CLOCK_SET_AUTO_REPEAT_EN
  localparam int unsigned RMAX = (REPEAT_DELAY > REPEAT_CYCLES) ? REPEAT_DELAY : REPEAT_CYCLES;
  localparam int unsigned RW = $clog2(RMAX + 1);
  localparam logic [RW-1:0] RPT_FIRST = RW'(REPEAT_DELAY - 1);
  localparam logic [RW-1:0] RPT_NEXT  = RW'(REPEAT_CYCLES - 1);

  logic [RW-1:0] rpt_cnt;
  logic          rpt_first, rpt_armed, rpt_hold, rpt_fire;

  // exactly one of inc/dec held, and only in the hour/minute fields
  assign rpt_hold = (db[1] ^ db[2]) && (state == SET_HR || state == SET_MIN);
  assign rpt_fire = rpt_hold && rpt_armed && !press[1] && !press[2] &&
                    (rpt_cnt == (rpt_first ? RPT_FIRST : RPT_NEXT));
  assign rpt_inc  = rpt_fire & db[1];
  assign rpt_dec  = rpt_fire & db[2];

  // repeat timer: armed by a press pulse, dropped as soon as the hold ends
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rpt_cnt   <= '0;
      rpt_first <= 1'b1;
      rpt_armed <= 1'b0;
    end else if (!rpt_hold) begin
      rpt_cnt   <= '0;
      rpt_first <= 1'b1;
      rpt_armed <= 1'b0;
    end else if (press[1] || press[2]) begin
      rpt_cnt   <= '0;
      rpt_first <= 1'b1;
      rpt_armed <= 1'b1;
    end else if (rpt_fire) begin
      rpt_cnt   <= '0;
      rpt_first <= 1'b0;
    end else begin
      rpt_cnt <= rpt_cnt + 1'b1;
    end
  end
`else
  assign rpt_inc = 1'b0;
  assign rpt_dec = 1'b0;
`endif

  assign in_set   = (state == SET_HR) || (state == SET_MIN) || (state == SET_SEC);
  assign timeout  = in_set && tick_1hz && (idle_cnt == TO_LAST);
  assign ev_inc   = press[1] | rpt_inc;
  assign ev_dec   = press[2] | rpt_dec;
  // timeout beats everything; mode beats inc/dec; inc+dec cancel
  assign act_mode = press[0] & ~timeout;
  assign act_inc  = ev_inc & ~ev_dec & ~press[0] & ~timeout;
  assign act_dec  = ev_dec & ~ev_inc & ~press[0] & ~timeout;

  // next BCD values for the hour and minute fields
  always_comb begin
    nh_t = e_hr_t;
    nh_o = e_hr_o;
    nm_t = e_min_t;
    nm_o = e_min_o;
    if (act_inc) begin
      if (e_hr_t == 2'd2 && e_hr_o == 4'd3) begin nh_t = '0; nh_o = '0; end
      else if (e_hr_o == 4'd9) begin nh_t = e_hr_t + 2'd1; nh_o = '0; end
      else nh_o = e_hr_o + 4'd1;
      if (e_min_t == 3'd5 && e_min_o == 4'd9) begin nm_t = '0; nm_o = '0; end
      else if (e_min_o == 4'd9) begin nm_t = e_min_t + 3'd1; nm_o = '0; end
      else nm_o = e_min_o + 4'd1;
    end else if (act_dec) begin
      if (e_hr_t == 2'd0 && e_hr_o == 4'd0) begin nh_t = 2'd2; nh_o = 4'd3; end
      else if (e_hr_o == 4'd0) begin nh_t = e_hr_t - 2'd1; nh_o = 4'd9; end
      else nh_o = e_hr_o - 4'd1;
      if (e_min_t == 3'd0 && e_min_o == 4'd0) begin nm_t = 3'd5; nm_o = 4'd9; end
      else if (e_min_o == 4'd0) begin nm_t = e_min_t - 3'd1; nm_o = 4'd9; end
      else nm_o = e_min_o - 4'd1;
    end
  end

  // edit FSM, edit registers, count enable and parallel-load outputs
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= RUN;
      count_en <= 1'b1;
      load     <= 1'b0;
      {ld_hr_tens, ld_hr_ones, ld_min_tens, ld_min_ones, ld_sec_tens, ld_sec_ones} <= '0;
      {e_hr_t, e_hr_o, e_min_t, e_min_o, e_sec_t, e_sec_o} <= '0;
    end else begin
      load <= 1'b0;
      case (state)
        RUN: begin
          count_en <= 1'b1;
          if (act_mode) begin
            {e_hr_t, e_hr_o}   <= {cur_hr_tens, cur_hr_ones};
            {e_min_t, e_min_o} <= {cur_min_tens, cur_min_ones};
            {e_sec_t, e_sec_o} <= {cur_sec_tens, cur_sec_ones};
            state    <= SET_HR;
            count_en <= 1'b0;
          end
        end
        SET_HR, SET_MIN, SET_SEC: begin
          if (timeout) begin
            state    <= RUN;
            count_en <= 1'b1;
          end else if (act_mode) begin
            if (state == SET_HR) state <= SET_MIN;
            else if (state == SET_MIN) state <= SET_SEC;
            else begin
              state <= COMMIT;
              load  <= 1'b1;
              {ld_hr_tens, ld_hr_ones}   <= {e_hr_t, e_hr_o};
              {ld_min_tens, ld_min_ones} <= {e_min_t, e_min_o};
              {ld_sec_tens, ld_sec_ones} <= {e_sec_t, e_sec_o};
            end
          end else if (state == SET_HR) begin
            {e_hr_t, e_hr_o} <= {nh_t, nh_o};
          end else if (state == SET_MIN) begin
            {e_min_t, e_min_o} <= {nm_t, nm_o};
          end else if (act_inc || act_dec) begin
            {e_sec_t, e_sec_o} <= '0;
          end
        end
        default: begin
          state    <= RUN;
          count_en <= 1'b1;
        end
      endcase
    end
  end

  // idle-second counter and blink phase while editing
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      idle_cnt <= '0;
      phase    <= 1'b0;
    end else if (!in_set) begin
      idle_cnt <= '0;
      phase    <= 1'b0;
    end else begin
      if (timeout || act_mode || act_inc || act_dec) idle_cnt <= '0;
      else if (tick_1hz) idle_cnt <= idle_cnt + 1'b1;
      if (act_inc || act_dec) phase <= 1'b0;
      else if (tick_1hz) phase <= ~phase;
    end
  end

  // blank the digits of the field being edited during the blink-off phase
  always_comb begin
    blank_mask = '0;
    if (phase) begin
      case (state)
        SET_HR:  blank_mask = 6'b110000;
        SET_MIN: blank_mask = 6'b001100;
        SET_SEC: blank_mask = 6'b000011;
        default: blank_mask = '0;
      endcase
    end
  end

  assign edit_state = state;

endmodule

// File: tb/tb_clock_set_controller.sv
// Bench for clock_set_controller: directed steps with randomized times and
// edit sequences, checked against an integer hours/minutes/seconds model.
module tb_clock_set_controller;

  logic       clk, rst, btn_mode, btn_inc, btn_dec, tick_1hz;
  logic [1:0] cur_hr_tens;  logic [3:0] cur_hr_ones;
  logic [2:0] cur_min_tens; logic [3:0] cur_min_ones;
  logic [2:0] cur_sec_tens; logic [3:0] cur_sec_ones;
  logic       count_en, load;
  logic [1:0] ld_hr_tens;  logic [3:0] ld_hr_ones;
  logic [2:0] ld_min_tens; logic [3:0] ld_min_ones;
  logic [2:0] ld_sec_tens; logic [3:0] ld_sec_ones;
  logic [5:0] blank_mask;
  logic [2:0] edit_state;

  int cur_h, cur_m, cur_s;   // live time presented to the DUT
  int m_h, m_m, m_s;         // model of the time being edited
  int n_pass, n_chk, n_fail;
  int load_cycles;
  logic [19:0] cap;

  clock_set_controller #(.DEBOUNCE_CYCLES(4), .TIMEOUT_S(3)) dut (
    .clk(clk), .rst(rst), .btn_mode(btn_mode), .btn_inc(btn_inc), .btn_dec(btn_dec),
    .tick_1hz(tick_1hz),
    .cur_hr_tens(cur_hr_tens), .cur_hr_ones(cur_hr_ones),
    .cur_min_tens(cur_min_tens), .cur_min_ones(cur_min_ones),
    .cur_sec_tens(cur_sec_tens), .cur_sec_ones(cur_sec_ones),
    .count_en(count_en), .load(load),
    .ld_hr_tens(ld_hr_tens), .ld_hr_ones(ld_hr_ones),
    .ld_min_tens(ld_min_tens), .ld_min_ones(ld_min_ones),
    .ld_sec_tens(ld_sec_tens), .ld_sec_ones(ld_sec_ones),
    .blank_mask(blank_mask), .edit_state(edit_state)
  );

  assign cur_hr_tens  = 2'(cur_h / 10);
  assign cur_hr_ones  = 4'(cur_h % 10);
  assign cur_min_tens = 3'(cur_m / 10);
  assign cur_min_ones = 4'(cur_m % 10);
  assign cur_sec_tens = 3'(cur_s / 10);
  assign cur_sec_ones = 4'(cur_s % 10);

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // count load cycles and capture the value presented while load is high
  always @(posedge clk) begin
    #1;
    if (load === 1'b1) begin
      load_cycles++;
      cap = {ld_hr_tens, ld_hr_ones, ld_min_tens, ld_min_ones, ld_sec_tens, ld_sec_ones};
    end
  end

  function automatic logic [19:0] pack(input int h, input int m, input int s);
    return {2'(h / 10), 4'(h % 10), 3'(m / 10), 4'(m % 10), 3'(s / 10), 4'(s % 10)};
  endfunction

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    assert (got === exp) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic step(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic press(input logic m, input logic i, input logic d);
    btn_mode = m; btn_inc = i; btn_dec = d;
    step(10);
    btn_mode = 1'b0; btn_inc = 1'b0; btn_dec = 1'b0;
    step(10);
  endtask

  task automatic tick();
    tick_1hz = 1'b1;
    step(1);
    tick_1hz = 1'b0;
    step(3);
  endtask

  // field: 0 hr, 1 min, 2 sec; op: 0 inc, 1 dec, 2 both (ignored)
  task automatic ed(input int field, input int op);
    press(1'b0, op != 1, op != 0);
    if (op != 2) begin
      if (field == 0) m_h = (m_h + ((op == 0) ? 1 : 23)) % 24;
      else if (field == 1) m_m = (m_m + ((op == 0) ? 1 : 59)) % 60;
      else m_s = 0;
    end
  endtask

  task automatic enter(input string tag);
    press(1'b1, 1'b0, 1'b0);
    m_h = cur_h; m_m = cur_m; m_s = cur_s;
    chk({tag, "_state"}, 32'(edit_state), 32'd1);
    chk({tag, "_count_en"}, 32'(count_en), 32'd0);
  endtask

  task automatic commit_check(input string tag);
    int lc0;
    lc0 = load_cycles;
    press(1'b1, 1'b0, 1'b0);
    chk({tag, "_load_cycles"}, 32'(load_cycles - lc0), 32'd1);
    chk({tag, "_ld_at_load"}, 32'(cap), 32'(pack(m_h, m_m, m_s)));
    chk({tag, "_ld_hold"}, 32'({ld_hr_tens, ld_hr_ones, ld_min_tens, ld_min_ones, ld_sec_tens, ld_sec_ones}),
        32'(pack(m_h, m_m, m_s)));
    chk({tag, "_run"}, 32'(edit_state), 32'd0);
    chk({tag, "_count_en"}, 32'(count_en), 32'd1);
  endtask

  task automatic rand_time();
    cur_h = int'($urandom_range(0, 23));
    cur_m = int'($urandom_range(0, 59));
    cur_s = int'($urandom_range(0, 59));
  endtask

  initial begin
    int lc0;
    n_pass = 0; n_chk = 0; n_fail = 0; load_cycles = 0; cap = '0;
    btn_mode = 0; btn_inc = 0; btn_dec = 0; tick_1hz = 0;
    cur_h = 12; cur_m = 34; cur_s = 56;
    rst = 1'b1;
    step(3);
    chk("rst_count_en", 32'(count_en), 32'd1);
    chk("rst_load", 32'(load), 32'd0);
    chk("rst_ld", 32'({ld_hr_tens, ld_hr_ones, ld_min_tens, ld_min_ones, ld_sec_tens, ld_sec_ones}), 32'd0);
    chk("rst_blank", 32'(blank_mask), 32'd0);
    chk("rst_state", 32'(edit_state), 32'd0);
    rst = 1'b0;
    step(2);

    // entry copies the live time; commit unchanged
    enter("entry");
    chk("entry_blank", 32'(blank_mask), 32'd0);
    press(1'b1, 1'b0, 1'b0);
    press(1'b1, 1'b0, 1'b0);
    chk("entry_set_sec", 32'(edit_state), 32'd3);
    commit_check("entry_commit");

    // hour wraps
    cur_h = 23; cur_m = 10; cur_s = 5;
    enter("wrap_up");
    ed(0, 0);
    press(1'b1, 1'b0, 1'b0); press(1'b1, 1'b0, 1'b0);
    commit_check("hr_23_inc");
    cur_h = 0;
    enter("wrap_dn");
    ed(0, 1);
    press(1'b1, 1'b0, 1'b0); press(1'b1, 1'b0, 1'b0);
    commit_check("hr_00_dec");
    cur_h = 20;
    enter("hr20");
    ed(0, 1);
    ed(0, 2);
    press(1'b1, 1'b0, 1'b0); press(1'b1, 1'b0, 1'b0);
    commit_check("hr_20_dec");

    // full commit to 07:45:00 from a random live time
    rand_time();
    enter("full");
    while (m_h != 7) ed(0, (((7 - m_h + 24) % 24) <= 12) ? 0 : 1);
    press(1'b1, 1'b0, 1'b0);
    while (m_m != 45) ed(1, (((45 - m_m + 60) % 60) <= 30) ? 0 : 1);
    press(1'b1, 1'b0, 1'b0);
    ed(2, int'($urandom_range(0, 1)));
    commit_check("full_0745");

    // randomized edit sequences
    for (int it = 0; it < 5; it++) begin
      rand_time();
      enter("rnd");
      for (int k = 0; k < 4; k++) ed(0, int'($urandom_range(0, 2)));
      press(1'b1, 1'b0, 1'b0);
      for (int k = 0; k < 4; k++) ed(1, int'($urandom_range(0, 2)));
      press(1'b1, 1'b0, 1'b0);
      if ($urandom_range(0, 1) == 1) ed(2, int'($urandom_range(0, 2)));
      commit_check("rnd_commit");
    end

    // bounce rejection then one clean press, in the minutes field
    rand_time();
    enter("bounce");
    press(1'b1, 1'b0, 1'b0);
    for (int k = 0; k < 20; k++) begin
      btn_inc = ~btn_inc;
      step(2);
    end
    btn_inc = 1'b0;
    step(10);
    btn_inc = 1'b1;
    step(6);
    btn_inc = 1'b0;
    step(12);
    m_m = (m_m + 1) % 60;
    chk("bounce_state", 32'(edit_state), 32'd2);
    press(1'b1, 1'b0, 1'b0);
    commit_check("bounce_commit");

    // timeout in SET_MIN
    rand_time();
    enter("tmo");
    press(1'b1, 1'b0, 1'b0);
    lc0 = load_cycles;
    tick();
    tick();
    chk("tmo_before", 32'(edit_state), 32'd2);
    tick();
    chk("tmo_state", 32'(edit_state), 32'd0);
    chk("tmo_count_en", 32'(count_en), 32'd1);
    chk("tmo_no_load", 32'(load_cycles - lc0), 32'd0);
    chk("tmo_blank", 32'(blank_mask), 32'd0);

    // blink and asynchronous reset mid-edit
    rand_time();
    enter("blink");
    press(1'b1, 1'b0, 1'b0);
    chk("blink_min_0", 32'(blank_mask), 32'h00);
    tick();
    chk("blink_min_1", 32'(blank_mask), 32'h0c);
    tick();
    chk("blink_min_2", 32'(blank_mask), 32'h00);
    press(1'b1, 1'b0, 1'b0);
    tick();
    chk("blink_sec_1", 32'(blank_mask), 32'h03);
    ed(2, 0);
    chk("blink_inc_forces", 32'(blank_mask), 32'h00);
    tick();
    chk("blink_sec_2", 32'(blank_mask), 32'h03);
    lc0 = load_cycles;
    #2 rst = 1'b1;
    #1;
    chk("arst_blank", 32'(blank_mask), 32'd0);
    chk("arst_count_en", 32'(count_en), 32'd1);
    chk("arst_load", 32'(load), 32'd0);
    chk("arst_state", 32'(edit_state), 32'd0);
    step(2);
    rst = 1'b0;
    step(3);
    chk("arst_no_load", 32'(load_cycles - lc0), 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
